rh_intr: RTL and testbench

RH11 interrupt request controller. Sits directly downstream of the CS1 register: it watches the assembled CS1 word and CPU writes to CS1, and from those decides when the RH11 raises a Unibus interrupt. It holds the request on the selected bus-request level until the UBA acknowledges it. It then returns a one-cycle `rhIACK` pulse that clears CS1[IE].

---
 rtl/rh_intr.sv | 93 +++++++++
 tb/tb_rh_intr.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/rh_intr.sv
// RH11 interrupt request controller: turns CS1 ready/special-condition edges and
// IE writes into a held Unibus request, then pulses rhIACK once the UBA acknowledges.
module rh_intr #(
    parameter logic [7:1] rhINTR = 7'b0001000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        devRESET,
    input  logic        rhCLR,
    input  logic        rhcs1WRITE,
    input  logic        devLOBYTE,
    input  logic [0:35] rhDATAI,
    input  logic [15:0] rhCS1,
    input  logic        devINTA,
    output logic [7:1]  devINTR,
    output logic        rhIACK,
    output logic        intPEND
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_ACK  = 2'b10
    } state_t;

    state_t state_r;
    state_t state_s;
    logic   last_rdy_r;
    logic   last_sc_r;
    logic   edge_vld_r;
    logic   clear_s;
    logic   trig_s;
    logic   cancel_s;
    logic   ie_wr_s;

    // Edge history is only meaningful once it has captured a real CS1 sample,
    // so a level already present when reset/clear releases is not seen as an edge.
    always_comb begin
        clear_s  = devRESET | rhCLR;
        ie_wr_s  = rhDATAI[29];
        trig_s   = (rhCS1[6] & rhCS1[7]  & ~last_rdy_r & edge_vld_r) |
                   (rhCS1[6] & rhCS1[15] & ~last_sc_r  & edge_vld_r) |
                   (rhcs1WRITE & devLOBYTE & ie_wr_s & rhCS1[7]);
        cancel_s = rhcs1WRITE & devLOBYTE & ~ie_wr_s;
    end

    // Next-state logic; cancel takes priority over a simultaneous acknowledge.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (trig_s) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (cancel_s) begin
                    state_s = ST_IDLE;
                end else if (devINTA) begin
                    state_s = ST_ACK;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_ACK:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, edge history and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst || clear_s) begin
            state_r    <= ST_IDLE;
            last_rdy_r <= 1'b0;
            last_sc_r  <= 1'b0;
            edge_vld_r <= 1'b0;
            devINTR    <= 7'b0000000;
            rhIACK     <= 1'b0;
            intPEND    <= 1'b0;
        end else begin
            state_r    <= state_s;
            last_rdy_r <= rhCS1[7];
            last_sc_r  <= rhCS1[15];
            edge_vld_r <= 1'b1;
            devINTR    <= (state_s == ST_REQ) ? rhINTR : 7'b0000000;
            rhIACK     <= (state_s == ST_ACK);
            intPEND    <= (state_s == ST_REQ);
        end
    end

endmodule

// File: tb/tb_rh_intr.sv
// Directed, table-driven bench for rh_intr: one row per clock of inputs and the
// outputs expected just after that edge, plus a held-acknowledge sequence.
module tb_rh_intr;

    logic        clk = 1'b0;
    logic        rst;
    logic        devRESET;
    logic        rhCLR;
    logic        rhcs1WRITE;
    logic        devLOBYTE;
    logic [0:35] rhDATAI;
    logic [15:0] rhCS1;
    logic        devINTA;
    logic [7:1]  devINTR;
    logic        rhIACK;
    logic        intPEND;

    int errors = 0;
    int checks = 0;

    rh_intr dut (
        .clk(clk), .rst(rst), .devRESET(devRESET), .rhCLR(rhCLR),
        .rhcs1WRITE(rhcs1WRITE), .devLOBYTE(devLOBYTE), .rhDATAI(rhDATAI),
        .rhCS1(rhCS1), .devINTA(devINTA), .devINTR(devINTR),
        .rhIACK(rhIACK), .intPEND(intPEND)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        dres;
        logic        clr;
        logic        wr;
        logic        lo;
        logic        d6;
        logic [15:0] cs1;
        logic        inta;
        logic [6:0]  eintr;
        logic        eiack;
        logic        epend;
    } vec_t;

    vec_t vecs[$];

    localparam logic [6:0] BR4 = 7'b0001000;
    localparam logic [6:0] NONE = 7'b0000000;

    task automatic add(input logic r, input logic dr, input logic cl, input logic w,
                       input logic l, input logic d, input logic [15:0] c, input logic a,
                       input logic [6:0] ei, input logic ek, input logic ep);
        vec_t v;
        v.rst = r; v.dres = dr; v.clr = cl; v.wr = w; v.lo = l; v.d6 = d;
        v.cs1 = c; v.inta = a; v.eintr = ei; v.eiack = ek; v.epend = ep;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; devRESET = v.dres; rhCLR = v.clr;
        rhcs1WRITE = v.wr; devLOBYTE = v.lo;
        rhDATAI = v.d6 ? 36'o100 : 36'o0;
        rhCS1 = v.cs1; devINTA = v.inta;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [6:0] ei, input logic ek, input logic ep);
        checks++;
        if (devINTR !== ei || rhIACK !== ek || intPEND !== ep) begin
            errors++;
            $display("FAIL %s: got intr=%b iack=%b pend=%b, want intr=%b iack=%b pend=%b",
                     name, devINTR, rhIACK, intPEND, ei, ek, ep);
        end
    endtask

    initial begin
        vec_t idle;
        int   pulses;
        //  rst dr cl wr lo d6 cs1       inta  intr  iack pend
        add(0, 0, 0, 0, 0, 0, 16'h00C0, 0, NONE, 0, 0); // reset
        add(0, 0, 0, 0, 0, 0, 16'h00C0, 0, NONE, 0, 0);
        add(1, 0, 0, 0, 0, 0, 16'h00C0, 0, NONE, 0, 0); // level after reset is not an edge
        add(1, 0, 0, 0, 0, 0, 16'h00C0, 0, NONE, 0, 0);
        add(1, 0, 0, 0, 0, 0, 16'h0040, 0, NONE, 0, 0); // RDY drops
        add(1, 0, 0, 0, 0, 0, 16'h00C0, 0, BR4,  0, 1); // A: RDY rises
        add(1, 0, 0, 0, 0, 0, 16'h00C0, 0, BR4,  0, 1);
        add(1, 0, 0, 0, 0, 0, 16'h00C0, 1, NONE, 1, 0); // INTA -> ACK
        add(1, 0, 0, 0, 0, 0, 16'h00C0, 0, NONE, 0, 0);
        add(1, 0, 0, 0, 0, 0, 16'h0080, 0, NONE, 0, 0);
        add(1, 0, 0, 1, 1, 1, 16'h0080, 0, BR4,  0, 1); // C: set IE with RDY
        add(1, 0, 0, 0, 0, 0, 16'h00C0, 0, BR4,  0, 1); // held RDY, no A
        add(1, 0, 0, 0, 0, 0, 16'h00C0, 0, BR4,  0, 1);
        add(1, 0, 0, 1, 1, 0, 16'h00C0, 1, NONE, 0, 0); // cancel beats INTA
        add(1, 0, 0, 0, 0, 0, 16'h0080, 0, NONE, 0, 0);
        add(1, 0, 0, 1, 0, 1, 16'h0080, 0, NONE, 0, 0); // high byte write: no C
        add(1, 0, 0, 0, 0, 0, 16'h0040, 0, NONE, 0, 0);
        add(1, 0, 0, 0, 0, 0, 16'h80C0, 0, BR4,  0, 1); // A and B together
        add(1, 0, 0, 0, 0, 0, 16'h00C0, 0, BR4,  0, 1);
        add(1, 0, 0, 0, 0, 0, 16'h80C0, 0, BR4,  0, 1); // SC re-pulse merges
        add(1, 0, 0, 0, 0, 0, 16'h80C0, 1, NONE, 1, 0);
        add(1, 0, 0, 0, 0, 0, 16'h80C0, 1, NONE, 0, 0); // INTA ignored in ACK
        add(1, 0, 0, 0, 0, 0, 16'h80C0, 1, NONE, 0, 0); // INTA ignored in IDLE
        add(1, 0, 0, 0, 0, 0, 16'h80C0, 0, NONE, 0, 0);
        add(1, 0, 0, 0, 0, 0, 16'h8040, 0, NONE, 0, 0);
        add(1, 0, 0, 0, 0, 0, 16'h80C0, 0, BR4,  0, 1);
        add(1, 0, 0, 0, 0, 0, 16'h80C0, 1, NONE, 1, 0);
        add(1, 0, 1, 0, 0, 0, 16'h80C0, 0, NONE, 0, 0); // rhCLR in ACK cycle
        add(1, 0, 0, 0, 0, 0, 16'h80C0, 0, NONE, 0, 0);
        add(1, 0, 0, 0, 0, 0, 16'h80C0, 0, NONE, 0, 0);
        add(1, 0, 0, 1, 1, 1, 16'h0080, 0, BR4,  0, 1);
        add(1, 1, 0, 0, 0, 0, 16'h00C0, 0, NONE, 0, 0); // devRESET in REQ
        add(1, 0, 0, 0, 0, 0, 16'h00C0, 0, NONE, 0, 0);
        add(1, 0, 0, 0, 0, 0, 16'h00C0, 0, NONE, 0, 0);
        add(1, 0, 0, 1, 1, 1, 16'h0080, 0, BR4,  0, 1);
        add(1, 0, 0, 0, 0, 0, 16'h00C0, 1, NONE, 1, 0);
        add(1, 0, 0, 1, 1, 1, 16'h0080, 0, NONE, 0, 0); // trigger in ACK ignored
        add(1, 0, 0, 1, 1, 1, 16'h0080, 0, BR4,  0, 1); // back-to-back at M+2
        add(1, 0, 0, 1, 1, 0, 16'h0080, 0, NONE, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            tick();
            check($sformatf("vec%0d", i), vecs[i].eintr, vecs[i].eiack, vecs[i].epend);
        end

        // INTA held for four cycles yields a single acknowledge pulse.
        idle = vecs[vecs.size() - 1];
        idle.wr = 1'b1; idle.lo = 1'b1; idle.d6 = 1'b1;
        drive(idle);
        tick();
        check("held_req", BR4, 1'b0, 1'b1);
        idle.wr = 1'b0; idle.inta = 1'b1; idle.cs1 = 16'h00C0;
        drive(idle);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (rhIACK === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL held_inta_pulses: got %0d, want 1", pulses);
        end
        idle.inta = 1'b0;
        drive(idle);
        tick();
        check("held_end", NONE, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
